// File: rtl/bwd_ctrl_pipe_elastic.sv
// Elastic valid/ready backward-extension control pipeline with a pending curr-entry store.
// Define STALL_COMPAT_EN to add a global stall input that freezes the whole pipeline.
module bwd_ctrl_pipe_elastic #(
    parameter int         RN_W        = 9,
    parameter int         NUM_STAGES  = 3,
    parameter int         SEL_STAGE   = 1,
    parameter int         CTX_W       = 64,
    parameter int         ADDR_W      = 42,
    parameter int         ADDR_LSB    = 7,
    parameter logic [5:0] FINISH_CODE = 6'h20,
    parameter int         CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
`ifdef STALL_COMPAT_EN
    input  logic              stall,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RN_W-1:0]   in_read_num,
    input  logic [5:0]        in_status,
    input  logic              in_last_one,
    input  logic [63:0]       in_k,
    input  logic [63:0]       in_l,
    input  logic [255:0]      in_p,
    input  logic [CTX_W-1:0]  in_ctx,
    input  logic              curr_wr_en,
    input  logic [RN_W-1:0]   curr_wr_read,
    input  logic [255:0]      curr_wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RN_W-1:0]   out_read_num,
    output logic [5:0]        out_status,
    output logic [63:0]       out_k,
    output logic [63:0]       out_l,
    output logic [255:0]      out_p,
    output logic [CTX_W-1:0]  out_ctx,
    output logic              request_valid,
    output logic [ADDR_W-1:0] addr_k,
    output logic [ADDR_W-1:0] addr_l,
    output logic              finish_sign,
    output logic [CNT_W-1:0]  finish_cnt,
    output logic              miss_pulse,
    output logic              ovf_pulse
);

    localparam int DEPTH = 1 << RN_W;

    typedef struct packed {
        logic [RN_W-1:0]  read_num;
        logic [5:0]       status;
        logic             last_one;
        logic [63:0]      k;
        logic [63:0]      l;
        logic [255:0]     p;
        logic [CTX_W-1:0] ctx;
    } tok_t;

    tok_t                  stg [NUM_STAGES];
    tok_t                  src [NUM_STAGES];
    logic [NUM_STAGES-1:0] vld;
    logic [NUM_STAGES-1:0] src_vld;
    logic [NUM_STAGES-1:0] rdy;
    logic                  rdy_acc;
    logic                  go;

    logic [DEPTH-1:0]      ent_vld;
    logic [255:0]          ent_data [DEPTH];
    logic [255:0]          ent_rd;

    logic                  sel_vld;
    logic                  sel_last;
    logic [RN_W-1:0]       sel_read;
    logic                  sel_take;
    logic                  consume;
    logic                  miss;
    logic                  wr_ovf;

`ifdef STALL_COMPAT_EN
    assign go = !stall;
`else
    assign go = 1'b1;
`endif

    // A stage may load whenever it or any stage downstream of it is empty, or the sink drains.
    always_comb begin
        rdy_acc = out_ready & go;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            rdy_acc = go & (!vld[i] | rdy_acc);
            rdy[i]  = rdy_acc;
        end
    end

    generate
        if (SEL_STAGE == 0) begin : g_sel_in
            assign sel_vld  = in_valid;
            assign sel_last = in_last_one;
            assign sel_read = in_read_num;
        end else begin : g_sel_stg
            assign sel_vld  = vld[SEL_STAGE-1];
            assign sel_last = stg[SEL_STAGE-1].last_one;
            assign sel_read = stg[SEL_STAGE-1].read_num;
        end
    endgenerate

    assign sel_take = rdy[SEL_STAGE] & sel_vld & sel_last;
    assign consume  = sel_take & ent_vld[sel_read];
    assign miss     = sel_take & !ent_vld[sel_read];
    assign ent_rd   = ent_data[sel_read];
    // A write racing a consume of the same read refills a just-emptied slot, so it is not an overflow.
    assign wr_ovf   = go & curr_wr_en & ent_vld[curr_wr_read]
                      & !(consume && (sel_read == curr_wr_read));

    always_comb begin
        src[0] = '{read_num: in_read_num, status: in_status, last_one: in_last_one,
                   k: in_k, l: in_l, p: in_p, ctx: in_ctx};
        src_vld[0] = in_valid;
        for (int i = 1; i < NUM_STAGES; i++) begin
            src[i]     = stg[i-1];
            src_vld[i] = vld[i-1];
        end
        if (consume) src[SEL_STAGE].p = ent_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld    <= '0;
            addr_k <= '0;
            addr_l <= '0;
            for (int i = 0; i < NUM_STAGES; i++) stg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (rdy[i]) begin
                    vld[i] <= src_vld[i];
                    stg[i] <= src[i];
                end
            end
            if (rdy[NUM_STAGES-1]) begin
                addr_k <= src[NUM_STAGES-1].k[ADDR_LSB +: ADDR_W];
                addr_l <= src[NUM_STAGES-1].l[ADDR_LSB +: ADDR_W];
            end
        end
    end

    // Write after clear so a same-cycle write leaves the entry valid with the new data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_vld    <= '0;
            miss_pulse <= 1'b0;
            ovf_pulse  <= 1'b0;
            finish_cnt <= '0;
        end else begin
            miss_pulse <= miss;
            ovf_pulse  <= wr_ovf;
            if (consume) ent_vld[sel_read] <= 1'b0;
            if (curr_wr_en) ent_vld[curr_wr_read] <= 1'b1;
            if (out_valid & out_ready & go & finish_sign) finish_cnt <= finish_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (curr_wr_en) ent_data[curr_wr_read] <= curr_wr_data;
    end

    assign in_ready      = rdy[0];
    assign out_valid     = vld[NUM_STAGES-1];
    assign out_read_num  = stg[NUM_STAGES-1].read_num;
    assign out_status    = stg[NUM_STAGES-1].status;
    assign out_k         = stg[NUM_STAGES-1].k;
    assign out_l         = stg[NUM_STAGES-1].l;
    assign out_p         = stg[NUM_STAGES-1].p;
    assign out_ctx       = stg[NUM_STAGES-1].ctx;
    assign request_valid = out_valid & (out_status != FINISH_CODE);
    assign finish_sign   = out_valid & (out_status == FINISH_CODE);

endmodule

// File: tb/tb_bwd_ctrl_pipe_elastic.sv
// Self-checking bench for bwd_ctrl_pipe_elastic: directed scenarios plus randomized traffic
// checked against an in-order queue model of the pipeline and its pending store.
module tb_bwd_ctrl_pipe_elastic;
    localparam int         N   = 3;
    localparam logic [5:0] FIN = 6'h20;

    typedef struct packed {
        logic [8:0]   rn;
        logic [5:0]   st;
        logic         lo;
        logic [63:0]  k;
        logic [63:0]  l;
        logic [255:0] p;
        logic [63:0]  ctx;
    } tok_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stall = 1'b0;
    logic         in_valid, in_ready, in_last_one;
    logic [8:0]   in_read_num;
    logic [5:0]   in_status;
    logic [63:0]  in_k, in_l, in_ctx;
    logic [255:0] in_p;
    logic         curr_wr_en;
    logic [8:0]   curr_wr_read;
    logic [255:0] curr_wr_data;
    logic         out_valid, out_ready;
    logic [8:0]   out_read_num;
    logic [5:0]   out_status;
    logic [63:0]  out_k, out_l, out_ctx;
    logic [255:0] out_p;
    logic         request_valid, finish_sign, miss_pulse, ovf_pulse;
    logic [41:0]  addr_k, addr_l;
    logic [15:0]  finish_cnt;

    int           tests = 0;
    int           fails = 0;
    tok_t         exp_q[$];
    logic [255:0] mdl_data [512];
    bit   [511:0] mdl_vld;
    int           mdl_fin, miss_exp, miss_seen, ovf_exp, ovf_seen;
    logic         last_acc;
    logic [41:0]  last_req_addr;
    logic [255:0] cap_p;

    bwd_ctrl_pipe_elastic dut (
        .clk(clk), .rst(rst),
`ifdef STALL_COMPAT_EN
        .stall(stall),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_read_num(in_read_num),
        .in_status(in_status), .in_last_one(in_last_one), .in_k(in_k), .in_l(in_l),
        .in_p(in_p), .in_ctx(in_ctx), .curr_wr_en(curr_wr_en),
        .curr_wr_read(curr_wr_read), .curr_wr_data(curr_wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_read_num(out_read_num),
        .out_status(out_status), .out_k(out_k), .out_l(out_l), .out_p(out_p),
        .out_ctx(out_ctx), .request_valid(request_valid), .addr_k(addr_k),
        .addr_l(addr_l), .finish_sign(finish_sign), .finish_cnt(finish_cnt),
        .miss_pulse(miss_pulse), .ovf_pulse(ovf_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic tok_t mkTok(input logic [8:0] rn, input logic [5:0] st,
                                   input logic lo, input logic [63:0] k);
        tok_t t;
        t.rn  = rn;
        t.st  = st;
        t.lo  = lo;
        t.k   = k;
        t.l   = {$urandom, $urandom};
        t.p   = rand256();
        t.ctx = {$urandom, $urandom};
        return t;
    endfunction

    // One clock cycle: check outputs against the model, drive inputs, update the model.
    task automatic applyStimulus(input logic v, input tok_t t, input logic ordy,
                                 input logic we, input logic [8:0] wa, input logic [255:0] wd);
        tok_t e;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_out", out_valid, 1'b0);
            end else begin
                e = exp_q[0];
                checkOutput("out_tok", {out_read_num, out_status, out_k, out_l, out_p, out_ctx},
                            {e.rn, e.st, e.k, e.l, e.p, e.ctx});
                checkOutput("out_req", {request_valid, finish_sign, addr_k, addr_l},
                            {e.st != FIN, e.st == FIN, e.k[48:7], e.l[48:7]});
                if (request_valid) last_req_addr = addr_k;
            end
        end else begin
            checkOutput("idle_flags", {request_valid, finish_sign}, 2'b00);
        end
        checkOutput("finish_cnt", finish_cnt, 16'(mdl_fin));
        miss_seen += int'(miss_pulse);
        ovf_seen  += int'(ovf_pulse);

        in_valid = v;
        {in_read_num, in_status, in_last_one, in_k, in_l, in_p, in_ctx} = t;
        out_ready    = ordy;
        curr_wr_en   = we;
        curr_wr_read = wa;
        curr_wr_data = wd;
        #1;
        checkOutput("in_ready", in_ready, !stall && ((exp_q.size() < N) || ordy));

        if (out_valid && ordy && !stall && exp_q.size() > 0) begin
            if (exp_q[0].st == FIN) mdl_fin++;
            void'(exp_q.pop_front());
        end
        if (we) begin
            if (mdl_vld[wa]) ovf_exp++;
            mdl_vld[wa]  = 1'b1;
            mdl_data[wa] = wd;
        end
        last_acc = v && in_ready;
        if (last_acc) begin
            e = t;
            if (t.lo) begin
                if (mdl_vld[t.rn]) begin
                    e.p = mdl_data[t.rn];
                    mdl_vld[t.rn] = 1'b0;
                end else begin
                    miss_exp++;
                end
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (out_valid) cap_p = out_p;
            applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, '0);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            idle(1);
            n++;
        end
        if (exp_q.size() > 0) checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
        checkOutput("drain_out_valid", out_valid, 1'b0);
    endtask

    task automatic doReset();
        in_valid = 1'b0; out_ready = 1'b0; curr_wr_en = 1'b0; stall = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_outs", {out_valid, request_valid, finish_sign, miss_pulse, ovf_pulse}, 5'b0);
        checkOutput("rst_finish_cnt", finish_cnt, 16'd0);
        checkOutput("rst_addr", {addr_k, addr_l}, 84'd0);
        checkOutput("rst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        mdl_vld = '0;
        mdl_fin = 0; miss_exp = 0; miss_seen = 0; ovf_exp = 0; ovf_seen = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int   first_out;
        int   acc;
        tok_t t;
        logic [255:0] d_old, d_new;

        in_valid = 1'b0; out_ready = 1'b0; curr_wr_en = 1'b0; curr_wr_read = '0;
        curr_wr_data = '0; in_read_num = '0; in_status = '0; in_last_one = 1'b0;
        in_k = '0; in_l = '0; in_p = '0; in_ctx = '0;
        @(negedge clk);
        doReset();

        // Streaming with latency and order.
        first_out = -1; acc = 0;
        for (int i = 0; i < 16; i++) begin
            if (out_valid && first_out < 0) first_out = i;
            applyStimulus(i < 10, mkTok(9'(i), 6'h01, 1'b0, {$urandom, $urandom}), 1'b1, 1'b0, '0, '0);
            if (last_acc) acc++;
        end
        checkOutput("t1_latency", 32'(first_out), 32'(N));
        checkOutput("t1_accepted", 32'(acc), 32'd10);

        // Backpressure: only N tokens buffered.
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, mkTok(9'(32 + i), 6'h02, 1'b0, {$urandom, $urandom}), 1'b0, 1'b0, '0, '0);
            if (last_acc) acc++;
        end
        checkOutput("t2_buffered", 32'(acc), 32'(N));
        checkOutput("t2_in_ready_low", in_ready, 1'b0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, mkTok(9'(40 + i), 6'h02, 1'b0, {$urandom, $urandom}), 1'b1, 1'b0, '0, '0);
        drain();

        // Pending store consume, then miss.
        d_old = rand256();
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 9'd5, d_old);
        idle(2);
        applyStimulus(1'b1, mkTok(9'd5, 6'h03, 1'b1, {$urandom, $urandom}), 1'b1, 1'b0, '0, '0);
        idle(5);
        checkOutput("t3_p_from_store", cap_p, d_old);
        t = mkTok(9'd5, 6'h03, 1'b1, {$urandom, $urandom});
        applyStimulus(1'b1, t, 1'b1, 1'b0, '0, '0);
        idle(5);
        checkOutput("t3_p_passthrough", cap_p, t.p);
        checkOutput("t3_miss_count", 32'(miss_seen), 32'd1);

        // Same-cycle write and consume of read 3.
        d_old = rand256();
        d_new = rand256();
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 9'd3, d_old);
        idle(2);
        applyStimulus(1'b1, mkTok(9'd3, 6'h04, 1'b1, {$urandom, $urandom}), 1'b1, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 9'd3, d_new);
        idle(5);
        checkOutput("t4_old_used", cap_p, d_old);
        checkOutput("t4_no_ovf", 32'(ovf_seen), 32'd0);
        applyStimulus(1'b1, mkTok(9'd3, 6'h04, 1'b1, {$urandom, $urandom}), 1'b1, 1'b0, '0, '0);
        idle(5);
        checkOutput("t4_new_kept", cap_p, d_new);
        checkOutput("t4_miss_total", 32'(miss_seen), 32'(miss_exp));

        // Finish tokens and address extraction.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, mkTok(9'(10 + i), FIN, 1'b0, 64'h1_0000_0080), 1'b1, 1'b0, '0, '0);
        applyStimulus(1'b1, mkTok(9'd13, 6'h05, 1'b0, 64'h1_0000_0080), 1'b1, 1'b0, '0, '0);
        drain();
        checkOutput("t5_finish_cnt", finish_cnt, 16'd3);
        checkOutput("t5_addr_k", last_req_addr, 42'h200_0001);

        // Reset mid-flight flushes tokens and the store.
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 9'd5, rand256());
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, mkTok(9'(20 + i), FIN, 1'b0, {$urandom, $urandom}), 1'b0, 1'b0, '0, '0);
        checkOutput("t6_full_before", out_valid, 1'b1);
        doReset();
        idle(5);
        t = mkTok(9'd5, 6'h06, 1'b1, {$urandom, $urandom});
        applyStimulus(1'b1, t, 1'b1, 1'b0, '0, '0);
        idle(5);
        checkOutput("t6_store_flushed", cap_p, t.p);
        checkOutput("t6_miss_count", 32'(miss_seen), 32'd1);

`ifdef STALL_COMPAT_EN
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, mkTok(9'(24 + i), FIN, 1'b0, {$urandom, $urandom}), 1'b0, 1'b0, '0, '0);
        stall = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, mkTok(9'(28 + i), FIN, 1'b0, {$urandom, $urandom}), 1'b1, 1'b0, '0, '0);
        checkOutput("stall_cnt_hold", finish_cnt, 16'd0);
        stall = 1'b0;
        drain();
        checkOutput("stall_cnt_after", finish_cnt, 16'd3);
`endif

        // Randomized traffic with a preloaded store.
        doReset();
        for (int a = 0; a < 8; a++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 9'(a), rand256());
        for (int i = 0; i < 400; i++) begin
            t = mkTok(9'($urandom_range(0, 15)),
                      ($urandom_range(0, 3) == 0) ? FIN : 6'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), {$urandom, $urandom});
            applyStimulus($urandom_range(0, 3) != 0, t, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 7) == 0, 9'(16 + $urandom_range(0, 7)), rand256());
        end
        drain();
        idle(2);
        checkOutput("rand_miss_count", 32'(miss_seen), 32'(miss_exp));
        checkOutput("rand_ovf_count", 32'(ovf_seen), 32'(ovf_exp));
        checkOutput("rand_finish_cnt", finish_cnt, 16'(mdl_fin));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
